pooling_max_unit: RTL

- Max-pooling datapath directly downstream of the pooling input interface.
- Consumes the serial single-precision word stream (one word per in_valid cycle, row-major, INPUT_SIZE words per row, INPUT_SIZE rows per frame).
- Emits one pooled maximum per KERNEL_SIZE x KERNEL_SIZE window, in row-major order, to the next layer.
- Holds per-output-column partial maxima across the KERNEL_SIZE input rows of each window.

---
 rtl/pooling_pkg.sv | 28 ++
 rtl/fp32_max_cmp.sv | 13 +
 rtl/pooling_max_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pooling_pkg.sv
// Shared fp32 definitions for the max-pooling datapath: field positions,
// the word type and the sign-magnitude greater-than ordering.
package pooling_pkg;

   localparam int DATA_WIDTH    = 32;
   localparam int FP32_SIGN     = 31;
   localparam int FP32_EXP_MSB  = 30;
   localparam int FP32_EXP_LSB  = 23;
   localparam int FP32_MANT_MSB = 22;
   localparam int FP32_MANT_LSB = 0;

   typedef logic [DATA_WIDTH-1:0] fp32_t;

   // Sign-magnitude ordering; +0 ranks above -0 because the sign test comes first.
   function automatic logic fp32_gt(input fp32_t a, input fp32_t b);
      logic [FP32_EXP_MSB:FP32_MANT_LSB] mag_a;
      logic [FP32_EXP_MSB:FP32_MANT_LSB] mag_b;
      mag_a = {a[FP32_EXP_MSB:FP32_EXP_LSB], a[FP32_MANT_MSB:FP32_MANT_LSB]};
      mag_b = {b[FP32_EXP_MSB:FP32_EXP_LSB], b[FP32_MANT_MSB:FP32_MANT_LSB]};
      if (a[FP32_SIGN] != b[FP32_SIGN])
         return !a[FP32_SIGN];
      else if (!a[FP32_SIGN])
         return mag_a > mag_b;
      else
         return mag_a < mag_b;
   endfunction

endpackage

// File: rtl/fp32_max_cmp.sv
// Combinational fp32 max of a stored partial and a candidate word.
// The partial is returned on a tie so the earlier window element is kept.
module fp32_max_cmp
   import pooling_pkg::*;
(
   input  fp32_t partial,
   input  fp32_t cand,
   output fp32_t max_val
);

   assign max_val = fp32_gt(cand, partial) ? cand : partial;

endmodule

// File: rtl/pooling_max_unit.sv
// Streaming KERNEL_SIZE x KERNEL_SIZE max-pooling over a serial row-major
// fp32 feature map, keeping one partial maximum per output column.
module pooling_max_unit #(
   parameter int  INPUT_SIZE  = 6,
   parameter int  KERNEL_SIZE = 2,
   parameter int  DATA_WIDTH  = 32,
   localparam int OUT_SIZE    = INPUT_SIZE / KERNEL_SIZE,
   localparam int OC_W        = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [OC_W-1:0]       out_col,
   output logic                  frame_done,
   output logic                  busy
);

   import pooling_pkg::*;

   localparam int CW        = $clog2(INPUT_SIZE + 1);
   localparam int KW        = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int POOL_ROWS = OUT_SIZE * KERNEL_SIZE;
   localparam int PD        = 2 ** OC_W;

   localparam logic [CW-1:0] LAST_IDX  = CW'(INPUT_SIZE - 1);
   localparam logic [CW-1:0] OUT_LIM   = CW'(OUT_SIZE);
   localparam logic [CW-1:0] ROW_LIM   = CW'(POOL_ROWS);
   localparam logic [CW-1:0] LAST_OC   = CW'(OUT_SIZE - 1);
   localparam logic [CW-1:0] LAST_PROW = CW'(POOL_ROWS - 1);
   localparam logic [KW-1:0] K_LAST    = KW'(KERNEL_SIZE - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]    state;
   logic [CW-1:0] col, row, oc;
   logic [KW-1:0] kc, kr;
   logic [OC_W-1:0] oc_idx;
   fp32_t         partial [PD];
   fp32_t         part_rd, max_val, upd_val;
   logic          accept, in_window, win_open, win_close, last_word, last_win;
   logic          emit;

   logic                  vld_p1, done_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic [OC_W-1:0]       col_p1;

   assign oc_idx    = oc[OC_W-1:0];
   assign accept    = in_valid && !frame_start;
   assign in_window = (oc < OUT_LIM) && (row < ROW_LIM);
   assign win_open  = (kc == '0) && (kr == '0);
   assign win_close = (kc == K_LAST) && (kr == K_LAST);
   assign last_word = (row == LAST_IDX) && (col == LAST_IDX);
   assign last_win  = (oc == LAST_OC) && (row == LAST_PROW);
   assign emit      = accept && in_window && win_close;

   assign part_rd = partial[oc_idx];

   // Single comparator serves both the partial update and the pooled result.
   fp32_max_cmp u_cmp (
      .partial (part_rd),
      .cand    (data_in),
      .max_val (max_val)
   );

   assign upd_val = win_open ? data_in : max_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
         oc  <= '0;
         kc  <= '0;
         kr  <= '0;
      end else if (frame_start) begin
         col <= '0;
         row <= '0;
         oc  <= '0;
         kc  <= '0;
         kr  <= '0;
      end else if (in_valid) begin
         if (col == LAST_IDX) begin
            col <= '0;
            oc  <= '0;
            kc  <= '0;
            if (row == LAST_IDX) begin
               row <= '0;
               kr  <= '0;
            end else begin
               row <= row + 1'b1;
               kr  <= (kr == K_LAST) ? '0 : kr + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
            kc  <= (kc == K_LAST) ? '0 : kc + 1'b1;
            oc  <= (kc == K_LAST) ? oc + 1'b1 : oc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (frame_start || in_valid) state <= RUN;
            RUN:     if (accept && last_word) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PD; i++) partial[i] <= '0;
      end else if (frame_start) begin
         for (int i = 0; i < PD; i++) partial[i] <= '0;
      end else if (accept && in_window) begin
         partial[oc_idx] <= upd_val;
      end
   end

   // Output stage p1: result registered one cycle after the closing word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         done_p1 <= 1'b0;
         data_p1 <= '0;
         col_p1  <= '0;
      end else begin
         vld_p1  <= emit;
         done_p1 <= emit && last_win;
         if (emit) begin
            data_p1 <= upd_val;
            col_p1  <= oc_idx;
         end
      end
   end

   assign out_valid  = vld_p1;
   assign frame_done = done_p1;
   assign data_out   = data_p1;
   assign out_col    = col_p1;
   assign busy       = (state == RUN);

endmodule
